// File: rtl/reg_bank_arbiter_if.sv
// Bus bundle between the requester side and the register-bank arbiter.
// Command fields of requester i sit in slice i of the packed vectors.
interface reg_bank_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       req_we;
  logic [N_REQ*AW-1:0]    req_addr;
  logic [N_REQ*WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       rdata;
  logic                   rvalid;
  logic [IDW-1:0]         rid;
  logic                   busy;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rdata, rvalid, rid, busy
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rdata, rvalid, rid, busy
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter that shares one flip-flop register bank among N_REQ
// requesters. Each access takes two cycles: a grant cycle that latches the
// winner's command, then an access cycle that commits the write or returns
// registered read data tagged with the winner's id.
module reg_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2,
  parameter int IDW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_bank_arbiter_if.slave bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state, next_state;

  logic [IDW-1:0]   last;
  logic [IDW-1:0]   win;
  logic             win_found;
  logic [IDW-1:0]   cand;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;

  logic [IDW-1:0]   cur_id;
  logic             cur_we;
  logic [AW-1:0]    cur_addr;
  logic [WIDTH-1:0] cur_wdata;

  logic [N_REQ-1:0] gnt_q;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;
  logic [IDW-1:0]   rid_q;
  logic [WIDTH-1:0] bank [DEPTH];

  // State register; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state: grant whenever someone asks in IDLE, always return from ACCESS
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|bus.req) next_state = ACCESS;
      ACCESS:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Round-robin search starting one past the last winner, with wrap-around
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(last) + k) % N_REQ);
      if (!win_found && (|(bus.req & (N_REQ'(1) << cand)))) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  // Pick the winner's command fields out of the packed request vectors
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*AW +: AW];
        sel_wdata = bus.req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant/latch in IDLE, commit the access in ACCESS, bank and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= IDW'(N_REQ - 1);
      cur_id    <= '0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      gnt_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            cur_id    <= win;
            cur_we    <= sel_we;
            cur_addr  <= sel_addr;
            cur_wdata <= sel_wdata;
            gnt_q     <= N_REQ'(1) << win;
          end
        end
        ACCESS: begin
          if (cur_we) begin
            bank[cur_addr] <= cur_wdata;
          end else begin
            rdata_q  <= bank[cur_addr];
            rid_q    <= cur_id;
            rvalid_q <= 1'b1;
          end
          last <= cur_id;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rid    = rid_q;
  assign bus.busy   = (state == ACCESS);
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: a cycle table for the basic
// write/read and collision cases, plus hand sequences for reset, fairness,
// wrap-around and glitchy idle requests.
module tb_reg_bank_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int AW    = 2;
  localparam int IDW   = 2;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  reg_bank_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .AW(AW), .IDW(IDW)) bus ();

  reg_bank_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .AW(AW), .IDW(IDW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        rvalid;
    logic [7:0]  rdata;
    logic [1:0]  rid;
    logic        busy;
  } vec_t;

  vec_t vecs [10];

  // Drive one cycle of inputs at a falling edge, advance to the next falling edge
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] we,
                               input logic [7:0] a, input logic [31:0] d);
    bus.req       = r;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] egnt,
                             input logic erv, input logic ebusy);
    checks++;
    if (bus.gnt !== egnt || bus.rvalid !== erv || bus.busy !== ebusy) begin
      errors++;
      $display("[TB] FAIL %s: gnt=%b rvalid=%b busy=%b, expected gnt=%b rvalid=%b busy=%b",
               name, bus.gnt, bus.rvalid, bus.busy, egnt, erv, ebusy);
    end
  endtask

  task automatic checkData(input string name, input logic [7:0] erdata,
                           input logic [1:0] erid);
    checks++;
    if (bus.rdata !== erdata || bus.rid !== erid) begin
      errors++;
      $display("[TB] FAIL %s: rdata=%h rid=%0d, expected rdata=%h rid=%0d",
               name, bus.rdata, bus.rid, erdata, erid);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Two-cycle read by requester id of address a, expecting data exp
  task automatic readTxn(input string name, input int id, input logic [1:0] a,
                         input logic [7:0] exp);
    logic [3:0] onehot;
    logic [7:0] addrv;
    onehot = 4'b0001 << id;
    addrv  = 8'(a) << (id * AW);
    applyStimulus(onehot, 4'b0000, addrv, 32'h0);
    checkOutput({name, "_gnt"}, onehot, 1'b0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 8'h00, 32'h0);
    checkOutput({name, "_rv"}, 4'b0000, 1'b1, 1'b0);
    checkData({name, "_data"}, exp, 2'(id));
  endtask

  initial begin
    errors = 0;
    checks = 0;

    vecs[0] = '{req:4'b0001, we:4'b0001, addr:8'h02, wdata:32'h000000A5,
                gnt:4'b0001, rvalid:1'b0, rdata:8'h00, rid:2'd0, busy:1'b1};
    vecs[1] = '{req:4'b0000, we:4'b0000, addr:8'h00, wdata:32'h0,
                gnt:4'b0000, rvalid:1'b0, rdata:8'h00, rid:2'd0, busy:1'b0};
    vecs[2] = '{req:4'b0001, we:4'b0000, addr:8'h02, wdata:32'h0,
                gnt:4'b0001, rvalid:1'b0, rdata:8'h00, rid:2'd0, busy:1'b1};
    vecs[3] = '{req:4'b0000, we:4'b0000, addr:8'h00, wdata:32'h0,
                gnt:4'b0000, rvalid:1'b1, rdata:8'hA5, rid:2'd0, busy:1'b0};
    vecs[4] = '{req:4'b0000, we:4'b0000, addr:8'h00, wdata:32'h0,
                gnt:4'b0000, rvalid:1'b0, rdata:8'hA5, rid:2'd0, busy:1'b0};
    vecs[5] = '{req:4'b0110, we:4'b0010, addr:8'h3C, wdata:32'h00003C00,
                gnt:4'b0010, rvalid:1'b0, rdata:8'hA5, rid:2'd0, busy:1'b1};
    vecs[6] = '{req:4'b0100, we:4'b0000, addr:8'h30, wdata:32'h0,
                gnt:4'b0000, rvalid:1'b0, rdata:8'hA5, rid:2'd0, busy:1'b0};
    vecs[7] = '{req:4'b0100, we:4'b0000, addr:8'h30, wdata:32'h0,
                gnt:4'b0100, rvalid:1'b0, rdata:8'hA5, rid:2'd0, busy:1'b1};
    vecs[8] = '{req:4'b0000, we:4'b0000, addr:8'h00, wdata:32'h0,
                gnt:4'b0000, rvalid:1'b1, rdata:8'h3C, rid:2'd2, busy:1'b0};
    vecs[9] = '{req:4'b0000, we:4'b0000, addr:8'h00, wdata:32'h0,
                gnt:4'b0000, rvalid:1'b0, rdata:8'h3C, rid:2'd2, busy:1'b0};

    rst_n = 1'b0;
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", 4'b0000, 1'b0, 1'b0);
    checkData("reset_data", 8'h00, 2'd0);
    rst_n = 1'b1;

    // Single write/read, then write/read collision on address 3
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d_ctrl", i), vecs[i].gnt, vecs[i].rvalid, vecs[i].busy);
      checkData($sformatf("vec%0d_data", i), vecs[i].rdata, vecs[i].rid);
    end

    // Requests that rise and fall between clock edges must never be granted
    for (int i = 0; i < 4; i++) begin
      #1 bus.req = 4'b1111;
      bus.req_we = 4'b1111;
      bus.req_wdata = 32'hFFFF_FFFF;
      #2 bus.req = 4'b0000;
      @(negedge clk);
      checkOutput($sformatf("glitch%0d_ctrl", i), 4'b0000, 1'b0, 1'b0);
    end
    bus.req_we = '0;
    bus.req_wdata = '0;
    readTxn("glitch_bank3", 3, 2'd3, 8'h3C);
    readTxn("glitch_bank2", 0, 2'd2, 8'hA5);

    // Wrap-around: after requester 1 wins, 3 beats 0
    doReset();
    readTxn("wrap_setup", 1, 2'd0, 8'h00);
    applyStimulus(4'b1001, 4'b0000, 8'h00, 32'h0);
    checkOutput("wrap_g3", 4'b1000, 1'b0, 1'b1);
    applyStimulus(4'b0001, 4'b0000, 8'h00, 32'h0);
    checkOutput("wrap_rv3", 4'b0000, 1'b1, 1'b0);
    checkData("wrap_rid3", 8'h00, 2'd3);
    applyStimulus(4'b0001, 4'b0000, 8'h00, 32'h0);
    checkOutput("wrap_g0", 4'b0001, 1'b0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 8'h00, 32'h0);
    checkOutput("wrap_rv0", 4'b0000, 1'b1, 1'b0);
    checkData("wrap_rid0", 8'h00, 2'd0);

    // All four keep requesting: strict round-robin from requester 0
    doReset();
    for (int t = 0; t < 8; t++) begin
      applyStimulus(4'b1111, 4'b0000, 8'h00, 32'h0);
      checkOutput($sformatf("rr%0d_gnt", t), 4'b0001 << (t % 4), 1'b0, 1'b1);
      applyStimulus(4'b1111, 4'b0000, 8'h00, 32'h0);
      checkOutput($sformatf("rr%0d_rv", t), 4'b0000, 1'b1, 1'b0);
      checkData($sformatf("rr%0d_rid", t), 8'h00, 2'(t % 4));
    end

    // Reset asserted while a write is in ACCESS drops the write
    doReset();
    applyStimulus(4'b0001, 4'b0001, 8'h01, 32'h0000005A);
    checkOutput("rstmid_gnt", 4'b0001, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_async", 4'b0000, 1'b0, 1'b0);
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstmid_hold", 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    readTxn("rstmid_word", 0, 2'd1, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
